// File: rtl/sram_wr_feeder_pkg.sv
// Shared constants and FSM encoding for the SRAM write feeder.
// The controller also uses these constants.
package sram_wr_feeder_pkg;

  localparam int DSIZE      = 16;
  localparam int ASIZE      = 18;
  localparam int BURST      = 16;
  localparam int FIFO_DEPTH = 64;
  localparam int AW_FIFO    = 6;
  localparam int CNT_W      = $clog2(BURST + 1);

  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00001,
    ST_REQ      = 5'b00010,
    ST_XFER     = 5'b00100,
    ST_WAIT_ACK = 5'b01000,
    ST_GAP      = 5'b10000
  } state_e;

  // Start address of the following burst; wraps modulo 2^ASIZE.
  function automatic logic [ASIZE-1:0] next_burst_addr(input logic [ASIZE-1:0] addr);
    return addr + ASIZE'(BURST);
  endfunction

endpackage

// File: rtl/sram_wr_feeder_if.sv
// Bundle of the upstream stream, config and controller write-port signals.
// The feeder takes the slave modport. The environment or controller side takes master.
interface sram_wr_feeder_if;
  import sram_wr_feeder_pkg::*;

  logic [DSIZE-1:0]   in_data_i;
  logic               in_valid_i;
  logic               in_ready_o;
  logic [ASIZE-1:0]   cfg_base_addr_i;
  logic               cfg_load_i;
  logic               wreq_o;
  logic [ASIZE-1:0]   wr_addr_o;
  logic [DSIZE-1:0]   wr_data_o;
  logic               sram_wr_valid_i;
  logic               sram_wr_ack_i;
  logic [AW_FIFO:0]   fifo_level_o;
  logic [15:0]        burst_cnt_o;
  logic               err_o;

  modport slave (
    input  in_data_i, in_valid_i, cfg_base_addr_i, cfg_load_i,
           sram_wr_valid_i, sram_wr_ack_i,
    output in_ready_o, wreq_o, wr_addr_o, wr_data_o,
           fifo_level_o, burst_cnt_o, err_o
  );

  modport master (
    output in_data_i, in_valid_i, cfg_base_addr_i, cfg_load_i,
           sram_wr_valid_i, sram_wr_ack_i,
    input  in_ready_o, wreq_o, wr_addr_o, wr_data_o,
           fifo_level_o, burst_cnt_o, err_o
  );

endinterface

// File: rtl/sram_wr_feeder_sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO. The head word is read combinationally from memory.
// Push is ignored when full and pop is ignored when empty.
module sync_fifo_fwft #(
  parameter int DSIZE   = 16,
  parameter int AW_FIFO = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [DSIZE-1:0]   data_i,
  output logic [DSIZE-1:0]   data_o,
  output logic [AW_FIFO:0]   level_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int DEPTH = 1 << AW_FIFO;

  logic [DSIZE-1:0]   mem_q [DEPTH];
  logic [AW_FIFO-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW_FIFO:0]   level_q;
  logic               do_push, do_pop;

  assign full_o  = (level_q == (AW_FIFO+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Storage carries no reset. Stale contents are unreachable because the level is reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_wr_feeder.sv
// Buffers upstream words and issues fixed-length burst write requests to the SRAM controller.
// The address auto-increments per burst, and protocol violations latch a sticky error.
module sram_wr_feeder
  import sram_wr_feeder_pkg::*;
(
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  sram_wr_feeder_if.slave bus
);

  state_e             state_q;
  logic               wreq_q;
  logic [ASIZE-1:0]   wr_addr_q;
  logic [ASIZE-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   word_cnt_q;
  logic [15:0]        burst_cnt_q;
  logic               err_q, err_d;

  logic [AW_FIFO:0]   level;
  logic [DSIZE-1:0]   head;
  logic               full, empty;
  logic               serving, pop;

  assign serving = (state_q == ST_REQ) || (state_q == ST_XFER);
  assign pop     = serving && bus.sram_wr_valid_i && !empty;

  sync_fifo_fwft #(
    .DSIZE   (DSIZE),
    .AW_FIFO (AW_FIFO)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .push_i  (bus.in_valid_i),
    .pop_i   (pop),
    .data_i  (bus.in_data_i),
    .data_o  (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.in_ready_o   = ~full;
  assign bus.wr_data_o    = head;
  assign bus.fifo_level_o = level;
  assign bus.wreq_o       = wreq_q;
  assign bus.wr_addr_o    = wr_addr_q;
  assign bus.burst_cnt_o  = burst_cnt_q;
  assign bus.err_o        = err_q;

  always_comb begin
    err_d = err_q;
    if (bus.cfg_load_i && state_q != ST_IDLE)             err_d = 1'b1;
    if (bus.sram_wr_ack_i && state_q != ST_WAIT_ACK)      err_d = 1'b1;
    if (serving && bus.sram_wr_valid_i && empty)          err_d = 1'b1;
    if (state_q == ST_WAIT_ACK && bus.sram_wr_valid_i)    err_d = 1'b1;
  end

  // A load that coincides with the IDLE->REQ decision is forwarded into that request.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && bus.cfg_load_i)
      ptr_d = bus.cfg_base_addr_i;
    else if (state_q == ST_WAIT_ACK && bus.sram_wr_ack_i)
      ptr_d = next_burst_addr(ptr_q);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      wreq_q      <= 1'b0;
      wr_addr_q   <= '0;
      ptr_q       <= '0;
      word_cnt_q  <= '0;
      burst_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= err_d;
      ptr_q <= ptr_d;
      case (state_q)
        ST_IDLE: begin
          if (level >= (AW_FIFO+1)'(BURST)) begin
            state_q   <= ST_REQ;
            wreq_q    <= 1'b1;
            wr_addr_q <= ptr_d;
          end
        end
        ST_REQ: begin
          if (pop) begin
            state_q    <= ST_XFER;
            word_cnt_q <= CNT_W'(1);
          end
        end
        ST_XFER: begin
          if (pop) begin
            word_cnt_q <= word_cnt_q + 1'b1;
            if (word_cnt_q == CNT_W'(BURST - 1)) state_q <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (bus.sram_wr_ack_i) begin
            state_q     <= ST_GAP;
            wreq_q      <= 1'b0;
            burst_cnt_q <= burst_cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          // Holding wreq low for this cycle guarantees the controller a fresh rising edge.
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          wreq_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_wr_feeder.sv
// Directed-plus-random bench for sram_wr_feeder with a queue-based reference model
// and a simple controller model driving strobes and acks.
module tb_sram_wr_feeder;
  import sram_wr_feeder_pkg::*;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  sram_wr_feeder_if bus();

  sram_wr_feeder dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [DSIZE-1:0] mq [$];
  logic [ASIZE-1:0] m_ptr;
  int               m_bursts;
  logic             m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_data_i       = '0;
    bus.in_valid_i      = 1'b0;
    bus.cfg_base_addr_i = '0;
    bus.cfg_load_i      = 1'b0;
    bus.sram_wr_valid_i = 1'b0;
    bus.sram_wr_ack_i   = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_ptr    = '0;
    m_bursts = 0;
    m_err    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    sys_rst_n = 1'b0;
    repeat (2) tick();
    sys_rst_n = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic load_base(input logic [ASIZE-1:0] a);
    bus.cfg_base_addr_i = a;
    bus.cfg_load_i      = 1'b1;
    tick();
    bus.cfg_load_i      = 1'b0;
    m_ptr = a;
  endtask

  task automatic push_word(input logic [DSIZE-1:0] d);
    logic acc;
    bus.in_data_i  = d;
    bus.in_valid_i = 1'b1;
    acc = bus.in_ready_o;
    tick();
    bus.in_valid_i = 1'b0;
    if (acc) mq.push_back(d);
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) push_word(DSIZE'($urandom));
  endtask

  // mode 0: strobe every cycle, 1: pattern 1,0,0, 2: random. cfg_at>=0 injects a load mid-burst.
  task automatic serve_burst(input int mode, input int cfg_at);
    int waitc = 0;
    int n     = 0;
    int step  = 0;
    logic v;
    while (bus.wreq_o !== 1'b1 && waitc < 100) begin
      tick();
      waitc++;
    end
    chk("wreq_seen", 32'(bus.wreq_o), 32'd1);
    if (bus.wreq_o !== 1'b1) return;
    chk("wr_addr", 32'(bus.wr_addr_o), 32'(m_ptr));
    while (n < BURST && step < 400) begin
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = (step % 3 == 0);
      else                v = 1'($urandom_range(0, 1));
      bus.sram_wr_valid_i = v;
      if (v && cfg_at >= 0 && n == cfg_at) begin
        bus.cfg_base_addr_i = 18'h2AAAA;
        bus.cfg_load_i      = 1'b1;
        m_err = 1'b1;
      end
      if (v) begin
        chk("wr_data", 32'(bus.wr_data_o), 32'(mq.pop_front()));
        n++;
      end
      tick();
      bus.sram_wr_valid_i = 1'b0;
      bus.cfg_load_i      = 1'b0;
      step++;
    end
    chk("pops", 32'(n), 32'(BURST));
    chk("wreq_hold", 32'(bus.wreq_o), 32'd1);
    repeat ($urandom_range(0, 3)) tick();
    bus.sram_wr_ack_i = 1'b1;
    tick();
    bus.sram_wr_ack_i = 1'b0;
    m_bursts++;
    m_ptr = m_ptr + ASIZE'(BURST);
    chk("wreq_gap", 32'(bus.wreq_o), 32'd0);
    chk("burst_cnt", 32'(bus.burst_cnt_o), 32'(m_bursts[15:0]));
    chk("level", 32'(bus.fifo_level_o), 32'(mq.size()));
    chk("err", 32'(bus.err_o), 32'(m_err));
  endtask

  initial begin
    idle_inputs();
    model_reset();
    tick();
    chk("rst_wreq",  32'(bus.wreq_o), 32'd0);
    chk("rst_level", 32'(bus.fifo_level_o), 32'd0);
    do_reset();
    chk("rst_ready", 32'(bus.in_ready_o), 32'd1);
    chk("rst_addr",  32'(bus.wr_addr_o), 32'd0);
    chk("rst_bcnt",  32'(bus.burst_cnt_o), 32'd0);
    chk("rst_err",   32'(bus.err_o), 32'd0);

    // Single burst with known data
    load_base(18'h00100);
    for (int i = 0; i < 15; i++) push_word(DSIZE'(i));
    push_word(DSIZE'(15));
    chk("level16", 32'(bus.fifo_level_o), 32'd16);
    chk("wreq_pre", 32'(bus.wreq_o), 32'd0);
    tick();
    chk("wreq_rise", 32'(bus.wreq_o), 32'd1);
    serve_burst(0, -1);

    // Back-to-back bursts
    push_n(48);
    serve_burst(0, -1);
    serve_burst(2, -1);
    serve_burst(0, -1);

    // Backpressure
    push_n(64);
    chk("full_ready", 32'(bus.in_ready_o), 32'd0);
    chk("full_level", 32'(bus.fifo_level_o), 32'd64);
    push_word(DSIZE'($urandom));
    chk("full_nopush", 32'(bus.fifo_level_o), 32'd64);
    serve_burst(2, -1);
    chk("bp_level48", 32'(bus.fifo_level_o), 32'd48);
    chk("bp_ready", 32'(bus.in_ready_o), 32'd1);
    serve_burst(1, -1);
    serve_burst(2, -1);
    serve_burst(0, -1);
    chk("stall_noerr", 32'(bus.err_o), 32'd0);

    // Address wrap
    tick();
    tick();
    load_base(18'h3FFF0);
    push_n(32);
    serve_burst(0, -1);
    serve_burst(2, -1);
    chk("wrap_addr", 32'(bus.wr_addr_o), 32'd0);

    // Config load during XFER is ignored and flags an error
    push_n(32);
    serve_burst(0, 5);
    serve_burst(0, -1);
    chk("cfg_err", 32'(bus.err_o), 32'd1);

    // Spurious ack in IDLE
    do_reset();
    chk("clr_err", 32'(bus.err_o), 32'd0);
    bus.sram_wr_ack_i = 1'b1;
    tick();
    bus.sram_wr_ack_i = 1'b0;
    chk("ack_err", 32'(bus.err_o), 32'd1);

    // Asynchronous reset mid-burst
    do_reset();
    load_base(18'h00100);
    push_n(16);
    repeat (2) tick();
    chk("mid_wreq", 32'(bus.wreq_o), 32'd1);
    bus.sram_wr_valid_i = 1'b1;
    repeat (5) tick();
    chk("mid_level", 32'(bus.fifo_level_o), 32'd11);
    sys_rst_n = 1'b0;
    #1;
    chk("arst_wreq",  32'(bus.wreq_o), 32'd0);
    chk("arst_level", 32'(bus.fifo_level_o), 32'd0);
    chk("arst_addr",  32'(bus.wr_addr_o), 32'd0);
    bus.sram_wr_valid_i = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    tick();
    model_reset();
    chk("arst_ready", 32'(bus.in_ready_o), 32'd1);
    chk("arst_err",   32'(bus.err_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
